axi_step_core_mc: RTL and testbench

//  N-channel AXI4-Lite stepper pulse generator; successor to the single-channel STEP core.
//  Per channel: programmable half-period, step count or continuous mode, latched direction, sticky done + IRQ.

---
 rtl/axi_step_core_mc_if.sv | 26 ++
 rtl/axi_step_core_mc.sv | 188 ++++++++++++++++++
 tb/tb_axi_step_core_mc.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_step_core_mc_if.sv
// AXI4-Lite slave bundle for the multi-channel step core.
interface axi_step_core_mc_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid, awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid, arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid, rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_step_core_mc.sv
// N-channel AXI4-Lite step/dir pulse generator. One channel block per step/dir pair,
// each owning its registers; the top does the AXI handshakes and address decode.
module axi_step_core_mc_ch #(
  parameter int PER_W = 24,
  parameter int CNT_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [1:0]  rd_off,
  output logic [31:0] rdata,
  output logic        step,
  output logic        dir,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
  state_t state, state_n;

  logic run, ctl_dir, cont, irq_en, cont_q, done;
  logic [PER_W-1:0] period, per_eff, cnt;
  logic [CNT_W-1:0] steps, steps_left;
  logic [31:0] mask, ctrl_w, per_w, steps_w;
  logic wr_ctrl, wr_per, wr_steps, wr_stat;
  logic start, finish, load, dec;
  logic unused_bits;

  assign mask     = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign ctrl_w   = ({28'd0, irq_en, cont, ctl_dir, run} & ~mask) | (wdata & mask);
  assign per_w    = (32'(period) & ~mask) | (wdata & mask);
  assign steps_w  = (32'(steps) & ~mask) | (wdata & mask);
  assign wr_ctrl  = wr_en && (wr_off == 2'd0);
  assign wr_per   = wr_en && (wr_off == 2'd1);
  assign wr_steps = wr_en && (wr_off == 2'd2);
  assign wr_stat  = wr_en && (wr_off == 2'd3);
  assign per_eff  = (period == '0) ? PER_W'(1) : period;
  assign unused_bits = ^{ctrl_w, per_w, steps_w};

  always_comb begin
    state_n = state;
    start   = 1'b0;
    finish  = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    case (state)
      IDLE:  if (wr_ctrl && ctrl_w[0] && !run) begin state_n = SETUP; start = 1'b1; end
      SETUP: if (!cont_q && steps_left == '0) begin state_n = IDLE; finish = 1'b1; end
             else begin state_n = HIGH; load = 1'b1; end
      HIGH:  if (cnt == '0) begin state_n = LOW; load = 1'b1; end
      LOW:   if (cnt == '0) begin
               if (cont_q) begin state_n = HIGH; load = 1'b1; end
               else if (steps_left <= CNT_W'(1)) begin
                 state_n = IDLE; finish = 1'b1; dec = (steps_left != '0);
               end else begin state_n = HIGH; load = 1'b1; dec = 1'b1; end
             end
      default: state_n = IDLE;
    endcase
    // Clearing run while moving aborts without flagging done.
    if (state != IDLE && wr_ctrl && !ctrl_w[0]) begin
      state_n = IDLE; finish = 1'b0; load = 1'b0; dec = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {run, ctl_dir, cont, irq_en} <= '0;
      {cont_q, dir, done}          <= '0;
      period     <= '0;
      steps      <= '0;
      steps_left <= '0;
      cnt        <= '0;
    end else begin
      if (wr_ctrl)  {irq_en, cont, ctl_dir, run} <= ctrl_w[3:0];
      if (finish)   run <= 1'b0;
      if (wr_per)   period <= per_w[PER_W-1:0];
      if (wr_steps) steps <= steps_w[CNT_W-1:0];
      if (wr_stat && wstrb[0] && wdata[1]) done <= 1'b0;
      if (start) begin
        dir        <= ctrl_w[1];
        cont_q     <= ctrl_w[2];
        steps_left <= steps;
        done       <= 1'b0;
      end
      if (finish) done <= 1'b1;
      if (load) cnt <= per_eff - PER_W'(1);
      else if ((state == HIGH || state == LOW) && cnt != '0) cnt <= cnt - PER_W'(1);
      if (dec) steps_left <= steps_left - CNT_W'(1);
    end
  end

  always_comb begin
    rdata = '0;
    case (rd_off)
      2'd0: rdata = {28'd0, irq_en, cont, ctl_dir, run};
      2'd1: rdata = 32'(period);
      2'd2: rdata = 32'(steps);
      2'd3: rdata = (32'(steps_left) << 8) | {30'd0, done, state != IDLE};
      default: rdata = '0;
    endcase
  end

  assign step = (state == HIGH);
  assign irq  = done & irq_en;
endmodule

module axi_step_core_mc #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int PER_W  = 24,
  parameter int CNT_W  = 24
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  axi_step_core_mc_if.slave s_axi,
  output logic [N_CH-1:0]   step_o,
  output logic [N_CH-1:0]   dir_o,
  output logic              irq_o
);
  localparam int CH_W = ADDR_W - 4;

  logic [CH_W-1:0] wch, rch;
  logic wr_hs, rd_hs, wch_ok, rch_ok, aw_go;
  logic [N_CH-1:0][DATA_W-1:0] ch_rdata;
  logic [N_CH-1:0] ch_irq;
  logic [DATA_W-1:0] rd_mux;
  logic unused_addr;

  assign wch    = s_axi.awaddr[ADDR_W-1:4];
  assign rch    = s_axi.araddr[ADDR_W-1:4];
  assign wch_ok = int'(wch) < N_CH;
  assign rch_ok = int'(rch) < N_CH;
  assign wr_hs  = s_axi.awready & s_axi.awvalid & s_axi.wvalid;
  assign rd_hs  = s_axi.arready & s_axi.arvalid;
  // Ready pulses for one cycle; the !awready term stops a second pulse before bvalid lands.
  assign aw_go  = s_axi.awvalid & s_axi.wvalid & ~s_axi.bvalid & ~s_axi.awready;
  assign unused_addr = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    axi_step_core_mc_ch #(.PER_W(PER_W), .CNT_W(CNT_W)) u_ch (
      .clk(ACLK), .rst_n(ARESETN),
      .wr_en(wr_hs && (int'(wch) == c)), .wr_off(s_axi.awaddr[3:2]),
      .wdata(s_axi.wdata), .wstrb(s_axi.wstrb), .rd_off(s_axi.araddr[3:2]),
      .rdata(ch_rdata[c]), .step(step_o[c]), .dir(dir_o[c]), .irq(ch_irq[c])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < N_CH; c++)
      if (int'(rch) == c) rd_mux = ch_rdata[c];
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= 2'b00;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rresp   <= 2'b00;
      s_axi.rdata   <= '0;
    end else begin
      s_axi.awready <= aw_go;
      s_axi.wready  <= aw_go;
      if (wr_hs) begin
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= wch_ok ? 2'b00 : 2'b10;
      end else if (s_axi.bready) s_axi.bvalid <= 1'b0;
      s_axi.arready <= s_axi.arvalid & ~s_axi.rvalid & ~s_axi.arready;
      if (rd_hs) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata  <= rch_ok ? rd_mux : '0;
        s_axi.rresp  <= rch_ok ? 2'b00 : 2'b10;
      end else if (s_axi.rready) s_axi.rvalid <= 1'b0;
    end
  end

  assign irq_o = |ch_irq;
endmodule

// File: tb/tb_axi_step_core_mc.sv
// Scoreboard bench for axi_step_core_mc: bus responses checked from queues, pulse trains from cycle patterns.
module tb_axi_step_core_mc;
  localparam int N_CH = 4;

  logic ACLK = 1'b0, ARESETN = 1'b0;
  logic [N_CH-1:0] step_o, dir_o;
  logic irq_o;

  axi_step_core_mc_if #(.ADDR_W(7)) bus();
  axi_step_core_mc #(.N_CH(N_CH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus), .step_o(step_o), .dir_o(dir_o), .irq_o(irq_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  rexp_t rq[$];
  logic [1:0] bq[$];
  int checks = 0, errors = 0;
  logic cnt_en = 1'b0;
  int rise0 = 0, rise1 = 0;
  logic [1:0] prev = 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK); #2;
  endtask

  always @(negedge ACLK) begin : mon
    rexp_t e;
    if (bus.bvalid && bus.bready) begin
      if (bq.size() == 0) chk("b_extra", 1, 0);
      else chk("bresp", bus.bresp, bq.pop_front());
    end
    if (bus.rvalid && bus.rready) begin
      if (rq.size() == 0) chk("r_extra", 1, 0);
      else begin
        e = rq.pop_front();
        chk("rdata", bus.rdata, e.data);
        chk("rresp", bus.rresp, e.resp);
      end
    end
  end

  always @(negedge ACLK) begin
    if (cnt_en) begin
      if (step_o[0] && !prev[0]) rise0++;
      if (step_o[1] && !prev[1]) rise1++;
    end
    prev = step_o[1:0];
  end

  // Returns in the cycle after the write lands (T+1) when b_hold is 0.
  task automatic axi_wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF,
                        input int w_lag = 0, input int b_hold = 0);
    int n;
    bq.push_back((int'(a[6:4]) < N_CH) ? 2'b00 : 2'b10);
    bus.bready  = (b_hold == 0);
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    for (int i = 0; i < w_lag; i++) begin tick(); chk("aw_wait", bus.awready, 0); end
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin tick(); n++; end
    if (!bus.awready) begin
      chk("aw_timeout", 0, 1);
      void'(bq.pop_back());
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
      return;
    end
    chk("wready", bus.wready, 1);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (b_hold > 0) begin
      for (int i = 0; i < b_hold; i++) begin chk("b_hold", bus.bvalid, 1); tick(); end
      bus.bready = 1'b1;
      tick();
    end
  endtask

  task automatic axi_rd(input logic [6:0] a, input logic [31:0] exp);
    int n;
    rq.push_back('{data: exp, resp: (int'(a[6:4]) < N_CH) ? 2'b00 : 2'b10});
    bus.rready  = 1'b1;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin tick(); n++; end
    if (!bus.arready) begin
      chk("ar_timeout", 0, 1);
      bus.arvalid = 1'b0;
      return;
    end
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (bus.rvalid && n < 20) begin tick(); n++; end
  endtask

  initial begin : wdog
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] obs, expv;
    logic lvl;
    int n;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    ARESETN = 1'b0;
    repeat (5) tick();
    chk("rst_step", step_o, 0);
    chk("rst_dir", dir_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_valids", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 0);
    chk("rst_rdata", bus.rdata, 0);
    ARESETN = 1'b1;
    tick();

    // reset mid-pulse
    axi_wr(7'h04, 3); axi_wr(7'h08, 5); axi_wr(7'h00, 32'hB);
    tick(); tick();
    chk("t1_pre_step", step_o[0], 1);
    ARESETN = 1'b0;
    tick();
    chk("t1_step", step_o, 0);
    chk("t1_dir", dir_o, 0);
    repeat (9) tick();
    chk("t1_irq", irq_o, 0);
    ARESETN = 1'b1;
    tick();
    axi_rd(7'h00, 0); axi_rd(7'h04, 0); axi_rd(7'h08, 0); axi_rd(7'h0C, 0);

    // ch0 counted run, 3/3 half-periods, 5 steps
    axi_wr(7'h04, 3); axi_wr(7'h08, 5); axi_wr(7'h00, 32'hB);
    chk("t2_dir", dir_o[0], 1);
    chk("t2_setup_step", step_o[0], 0);
    obs = '0; expv = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      obs[k] = step_o[0];
      expv[k] = (k % 6) < 3;
    end
    chk("t2_wave", obs, expv);
    tick();
    chk("t2_irq", irq_o, 1);
    chk("t2_idle_step", step_o[0], 0);
    axi_rd(7'h0C, 32'h2);
    axi_rd(7'h00, 32'hA);
    axi_wr(7'h0C, 32'h2);
    chk("t2_irq_clr", irq_o, 0);

    // ch2 continuous, live speed change, abort
    axi_wr(7'h24, 2); axi_wr(7'h20, 32'h5);
    obs = '0; expv = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      obs[k] = step_o[2];
      expv[k] = (k % 4) < 2;
    end
    chk("t3_wave", obs, expv);
    axi_wr(7'h24, 5);
    lvl = step_o[2]; n = 0;
    while (step_o[2] == lvl && n < 20) begin tick(); n++; end
    for (int p = 0; p < 2; p++) begin
      lvl = step_o[2]; n = 0;
      while (step_o[2] == lvl && n < 20) begin n++; tick(); end
      chk("t3_phase", n, 5);
    end
    axi_wr(7'h20, 32'h4);
    chk("t3_stop", step_o[2], 0);
    tick();
    chk("t3_stop_hold", step_o[2], 0);
    axi_rd(7'h2C, 0);
    axi_rd(7'h20, 32'h4);

    // ch1 STEPS=0, then PERIOD=0 STEPS=2
    axi_wr(7'h18, 0); axi_wr(7'h10, 32'h9);
    chk("t4_irq_t1", irq_o, 0);
    tick();
    chk("t4_irq_t2", irq_o, 1);
    obs = '0;
    for (int k = 0; k < 4; k++) begin tick(); obs[0] = obs[0] | step_o[1]; end
    chk("t4_no_pulse", obs, 0);
    axi_rd(7'h1C, 32'h2);
    axi_rd(7'h10, 32'h8);
    axi_wr(7'h14, 0); axi_wr(7'h18, 2); axi_wr(7'h10, 32'h1);
    obs = '0;
    for (int k = 0; k < 6; k++) begin tick(); obs[k] = step_o[1]; end
    chk("t4_min_wave", obs, 32'b000101);
    axi_rd(7'h1C, 32'h2);

    // AXI corner cases
    axi_wr(7'h34, 32'h123456, 4'hF, 3, 5);
    axi_rd(7'h34, 32'h123456);
    axi_wr(7'h34, 32'hFFFFFFAB, 4'h1);
    axi_rd(7'h34, 32'h1234AB);
    axi_wr(7'h40, 32'h1);
    axi_rd(7'h40, 0);

    // concurrent channels
    axi_wr(7'h04, 2); axi_wr(7'h08, 10); axi_wr(7'h14, 7); axi_wr(7'h18, 3);
    rise0 = 0; rise1 = 0; cnt_en = 1'b1;
    axi_wr(7'h00, 32'h1); axi_wr(7'h10, 32'h1);
    repeat (80) tick();
    cnt_en = 1'b0;
    chk("t6_ch0_steps", rise0, 10);
    chk("t6_ch1_steps", rise1, 3);
    axi_rd(7'h0C, 32'h2);
    axi_rd(7'h1C, 32'h2);

    repeat (3) tick();
    chk("rq_empty", rq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
